// File: rtl/four_bit_using_one_bit_comp_pkg.sv
// Shared types for the cascaded magnitude comparator.
// Holds the default operand width and the packed flag bundle that the top
// registers as one unit.
package four_bit_using_one_bit_comp_pkg;

  localparam int DEFAULT_WIDTH = 4;

  // Bit order matches the {lt,eq,gt} view used on the outputs.
  typedef struct packed {
    logic lt;
    logic eq;
    logic gt;
  } cmp_flags_t;

  localparam cmp_flags_t FLAGS_NONE = '{lt: 1'b0, eq: 1'b0, gt: 1'b0};

endpackage

// File: rtl/four_bit_using_one_bit_comp_one_bit_comp.sv
// Single-bit comparator cell. This block is purely combinational.
// Ports:
//   a, b   : input bits
//   lt     : output, high when a=0 and b=1
//   eq     : output, high when the two bits match
//   gt     : output, high when a=1 and b=0
module one_bit_comp (
  input  logic a,
  input  logic b,
  output logic lt,
  output logic eq,
  output logic gt
);

  assign lt = ~a & b;
  assign eq = ~(a ^ b);
  assign gt = a & ~b;

endmodule

// File: rtl/four_bit_using_one_bit_comp.sv
// Unsigned magnitude comparator built from WIDTH one-bit cells.
// The cells are scanned from MSB to LSB. The output flags are registered,
// which gives one cycle of latency.
// Ports:
//   clk     : clock, rising edge
//   rst     : synchronous, active-high; clears all flags ("no valid result")
//   a, b    : WIDTH-bit unsigned operands
//   lt/eq/gt: registered flags, exactly one of them is set once out of reset
module four_bit_using_one_bit_comp
  import four_bit_using_one_bit_comp_pkg::*;
#(
  parameter int WIDTH = DEFAULT_WIDTH
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [WIDTH-1:0] a,
  input  logic [WIDTH-1:0] b,
  output logic             lt,
  output logic             eq,
  output logic             gt
);

  logic [WIDTH-1:0] lt_c;
  logic [WIDTH-1:0] eq_c;
  logic [WIDTH-1:0] gt_c;

  // all_eq_above[i+1] is high when every bit above bit i is equal.
  // The top entry is the empty prefix, so it is tied to 1.
  // all_eq_above[0] is high when every bit is equal.
  logic [WIDTH:0]   all_eq_above;

  cmp_flags_t       flags_nxt;
  cmp_flags_t       flags_q;

  for (genvar i = 0; i < WIDTH; i++) begin : g_cell
    one_bit_comp u_cell (
      .a  (a[i]),
      .b  (b[i]),
      .lt (lt_c[i]),
      .eq (eq_c[i]),
      .gt (gt_c[i])
    );
  end

  assign all_eq_above[WIDTH] = 1'b1;
  for (genvar i = WIDTH - 1; i >= 0; i--) begin : g_chain
    assign all_eq_above[i] = all_eq_above[i+1] & eq_c[i];
  end

  // Only the first differing bit, counting from the MSB, can decide the
  // result. Every lower bit is masked off by the prefix-equal chain.
  assign flags_nxt.gt = |(all_eq_above[WIDTH:1] & gt_c);
  assign flags_nxt.lt = |(all_eq_above[WIDTH:1] & lt_c);
  assign flags_nxt.eq = all_eq_above[0];

  always_ff @(posedge clk) begin
    if (rst) flags_q <= FLAGS_NONE;
    else     flags_q <= flags_nxt;
  end

  assign lt = flags_q.lt;
  assign eq = flags_q.eq;
  assign gt = flags_q.gt;

endmodule

// File: tb/tb_four_bit_using_one_bit_comp.sv
module tb_four_bit_using_one_bit_comp;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic [3:0] a   = '0;
  logic [3:0] b   = '0;
  logic       lt, eq, gt;

  int n_vec = 0;
  int n_err = 0;
  int n_lt = 0, n_eq = 0, n_gt = 0;

  always #5 clk = ~clk;

  four_bit_using_one_bit_comp #(.WIDTH(4)) dut (
    .clk (clk),
    .rst (rst),
    .a   (a),
    .b   (b),
    .lt  (lt),
    .eq  (eq),
    .gt  (gt)
  );

  task automatic chk(input string tag, input int got, input int exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: compare the operands as plain integers.
  // The result is packed as {lt,eq,gt}. While reset is held, every flag is 0.
  function automatic int model(input int x, input int y, input bit r);
    if (r) return 0;
    return ((x < y) ? 4 : 0) | ((x == y) ? 2 : 0) | ((x > y) ? 1 : 0);
  endfunction

  // Apply the operands and reset value, clock one edge, then check the flags
  // shortly after that edge.
  task automatic step(input string tag, input int x, input int y, input bit r);
    int exp, got;
    a   = x[3:0];
    b   = y[3:0];
    rst = r;
    @(posedge clk);
    #1;
    exp = model(x, y, r);
    got = {29'd0, lt, eq, gt};
    chk(tag, got, exp);
    if (!r) chk({tag, "_onehot"}, $countones({lt, eq, gt}), 1);
  endtask

  initial begin
    // Reset is held for 2 cycles while the operands would give gt.
    step("rst0", 5, 3, 1'b1);
    step("rst1", 5, 3, 1'b1);
    step("rst_rel", 5, 3, 1'b0);

    // Sweep every pair of operands.
    for (int x = 0; x < 16; x++)
      for (int y = 0; y < 16; y++) begin
        step("sweep", x, y, 1'b0);
        n_lt += lt;
        n_eq += eq;
        n_gt += gt;
      end
    chk("sweep_eq_cnt", n_eq, 16);
    chk("sweep_lt_cnt", n_lt, 120);
    chk("sweep_gt_cnt", n_gt, 120);

    // A difference in the MSB decides the result, whatever the lower bits are.
    step("msb_gt", 8, 7, 1'b0);
    step("msb_lt", 7, 8, 1'b0);
    // A difference in the LSB decides the result.
    step("lsb_lt", 14, 15, 1'b0);
    step("lsb_gt", 15, 14, 1'b0);
    step("lsb_eq", 15, 15, 1'b0);

    // Back-to-back operands, one pair per edge.
    step("b2b_eq", 3, 3, 1'b0);
    step("b2b_lt", 3, 4, 1'b0);
    step("b2b_gt", 4, 3, 1'b0);
    // Reset asserted in the middle of the sequence.
    step("b2b_a", 3, 3, 1'b0);
    step("b2b_rst", 3, 4, 1'b1);
    step("b2b_post", 4, 3, 1'b0);

    // Extreme operands, each held for 3 cycles.
    for (int k = 0; k < 3; k++) step("ext_00", 0, 0, 1'b0);
    for (int k = 0; k < 3; k++) step("ext_0f", 0, 15, 1'b0);
    for (int k = 0; k < 3; k++) step("ext_f0", 15, 0, 1'b0);
    for (int k = 0; k < 3; k++) step("ext_ff", 15, 15, 1'b0);

    // Random operands, with reset asserted now and then.
    for (int k = 0; k < 400; k++)
      step("rand", int'($urandom_range(15)), int'($urandom_range(15)),
           ($urandom_range(15) == 0));

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
